// File: rtl/lidar_uart_pkg.sv
// Shared types and constants for the LiDAR UART frame transmitter.
// Holds the serialiser FSM states, default header and 8N1 framing constants.
package lidar_uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;

    localparam logic [15:0] LIDAR_HEADER = 16'h55AA;
    localparam int UART_DATA_BITS = 8;
    localparam int UART_STOP_BITS = 1;

    function automatic int frame_bytes(input int payload_bytes, input bit csum_en);
        return 2 + payload_bytes + (csum_en ? 1 : 0);
    endfunction

endpackage

// File: rtl/byte_if.sv
// Byte-level valid/ready handshake between the frame sequencer and serialiser.
// The source holds data stable while valid is high and ready is low.
interface byte_if;
    logic       valid;
    logic       ready;
    logic [7:0] data;

    modport src (output valid, output data, input ready);
    modport snk (input valid, input data, output ready);
endinterface

// File: rtl/uart_byte_tx.sv
// 8N1 byte serialiser with bit timer and registered txd.
// Accepts the next byte in the last stop-bit cycle so frames have no gaps.
module uart_byte_tx
    import lidar_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic  clock,
    input  logic  reset,
    byte_if.snk   byte_in,
    output logic  txd,
    output logic  done
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);
    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("uart_byte_tx: CLKS_PER_BIT must be >= 2");
    end

    uart_state_e   state, state_n;
    logic [TW-1:0] tmr, tmr_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    sh, sh_n;
    logic          txd_n;
    logic          tmr_end;

    assign tmr_end = (tmr == TMAX);
    assign byte_in.ready = (state == IDLE) || (state == STOP && tmr_end);

    always_comb begin
        state_n = state;
        tmr_n   = tmr + 1'b1;
        idx_n   = idx;
        sh_n    = sh;
        txd_n   = txd;
        done    = 1'b0;
        unique case (state)
            IDLE: begin
                tmr_n = '0;
                if (byte_in.valid) begin
                    state_n = START;
                    sh_n    = byte_in.data;
                    txd_n   = 1'b0;
                end
            end
            START: begin
                if (tmr_end) begin
                    state_n = DATA;
                    tmr_n   = '0;
                    idx_n   = '0;
                    txd_n   = sh[0];
                end
            end
            DATA: begin
                if (tmr_end) begin
                    tmr_n = '0;
                    if (idx == LAST_BIT) begin
                        state_n = STOP;
                        txd_n   = 1'b1;
                    end else begin
                        idx_n = idx + 1'b1;
                        sh_n  = sh >> 1;
                        txd_n = sh[1];
                    end
                end
            end
            STOP: begin
                if (tmr_end) begin
                    tmr_n = '0;
                    if (byte_in.valid) begin
                        state_n = START;
                        sh_n    = byte_in.data;
                        txd_n   = 1'b0;
                    end else begin
                        state_n = IDLE;
                        txd_n   = 1'b1;
                        done    = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
            tmr   <= '0;
            idx   <= '0;
            sh    <= '0;
            txd   <= 1'b1;
        end else begin
            state <= state_n;
            tmr   <= tmr_n;
            idx   <= idx_n;
            sh    <= sh_n;
            txd   <= txd_n;
        end
    end

endmodule

// File: rtl/lidar_frame_tx.sv
// LiDAR frame transmitter: header, payload (MSB byte first), optional XOR checksum.
// Sequences bytes into uart_byte_tx; all handshake/status outputs are registered.
module lidar_frame_tx
    import lidar_uart_pkg::*;
#(
    parameter int          CLKS_PER_BIT  = 868,
    parameter int          PAYLOAD_BYTES = 6,
    parameter logic [15:0] HEADER        = LIDAR_HEADER,
    parameter bit          CHECKSUM_EN   = 1'b1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       frame_valid,
    output logic                       frame_ready,
    input  logic [8*PAYLOAD_BYTES-1:0] payload,
    output logic                       txd,
    output logic                       tx_busy,
    output logic                       frame_done
);

    localparam int PW = 8 * PAYLOAD_BYTES;
    localparam int NB = frame_bytes(PAYLOAD_BYTES, CHECKSUM_EN);
    localparam int IW = $clog2(NB + 1);
    localparam logic [IW-1:0] ONE      = IW'(1);
    localparam logic [IW-1:0] LAST_PAY = IW'(PAYLOAD_BYTES + 1);
    localparam logic [IW-1:0] N_BYTES  = IW'(NB);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("lidar_frame_tx: CLKS_PER_BIT must be >= 2");
    end
    if (PAYLOAD_BYTES < 1 || PAYLOAD_BYTES > 32) begin : g_bad_len
        $error("lidar_frame_tx: PAYLOAD_BYTES must be in 1..32");
    end

    byte_if bus ();

    logic [IW-1:0] idx;
    logic [PW-1:0] pay_q;
    logic [7:0]    csum;
    logic          accept;
    logic          more;
    logic          fire;
    logic          done;
    logic          busy_n;

    assign accept    = frame_valid & frame_ready;
    assign more      = tx_busy & (idx < N_BYTES);
    assign fire      = more & bus.ready;
    assign bus.valid = accept | more;
    assign busy_n    = accept | (tx_busy & ~done);

    // idx counts bytes already handed to the serialiser
    always_comb begin
        bus.data = HEADER[15:8];
        unique case (1'b1)
            !tx_busy:
                bus.data = HEADER[15:8];
            tx_busy && idx == ONE:
                bus.data = HEADER[7:0];
            tx_busy && idx > ONE && idx <= LAST_PAY:
                bus.data = pay_q[PW-1 -: 8];
            default:
                bus.data = csum;
        endcase
    end

    uart_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clock   (clock),
        .reset   (reset),
        .byte_in (bus),
        .txd     (txd),
        .done    (done)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            tx_busy     <= 1'b0;
            frame_ready <= 1'b0;
            frame_done  <= 1'b0;
            idx         <= '0;
            pay_q       <= '0;
            csum        <= '0;
        end else begin
            tx_busy     <= busy_n;
            frame_ready <= ~busy_n;
            frame_done  <= done;
            if (accept) begin
                idx   <= ONE;
                pay_q <= payload;
                csum  <= HEADER[15:8];
            end else if (fire) begin
                idx  <= idx + ONE;
                csum <= csum ^ bus.data;
                if (idx > ONE) begin
                    pay_q <= pay_q << 8;
                end
            end
        end
    end

endmodule

// File: tb/tb_lidar_frame_tx.sv
// Bench for lidar_frame_tx: UART decoders feed a byte scoreboard.
// Two instances: default framing at CLKS_PER_BIT=4, and 1-byte no-checksum.
module tb_lidar_frame_tx;

    localparam int C1 = 4;
    localparam int C2 = 2;

    logic        clock;
    logic        reset;
    logic        valid1, ready1, txd1, busy1, done1;
    logic [47:0] payload1;
    logic        valid2, ready2, txd2, busy2, done2;
    logic [7:0]  payload2;

    int errors = 0;
    int checks = 0;
    int busy_cnt1 = 0, done_cnt1 = 0;
    int busy_cnt2 = 0, done_cnt2 = 0;
    bit mon_en1 = 1'b1;
    logic [7:0] q1[$];
    logic [7:0] q2[$];
    logic [7:0] b1, b2, e1, e2;

    lidar_frame_tx #(.CLKS_PER_BIT(C1)) dut1 (
        .clock(clock), .reset(reset),
        .frame_valid(valid1), .frame_ready(ready1),
        .payload(payload1), .txd(txd1),
        .tx_busy(busy1), .frame_done(done1)
    );

    lidar_frame_tx #(
        .CLKS_PER_BIT(C2), .PAYLOAD_BYTES(1), .CHECKSUM_EN(1'b0)
    ) dut2 (
        .clock(clock), .reset(reset),
        .frame_valid(valid2), .frame_ready(ready2),
        .payload(payload2), .txd(txd2),
        .tx_busy(busy2), .frame_done(done2)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(negedge clock) begin
        if (busy1 === 1'b1) busy_cnt1++;
        if (done1 === 1'b1) done_cnt1++;
        if (busy2 === 1'b1) busy_cnt2++;
        if (done2 === 1'b1) done_cnt2++;
    end

    // Decoder for dut1: samples mid-bit, checks stop bit, pops scoreboard
    initial begin
        forever begin
            @(negedge clock);
            if (mon_en1 && txd1 === 1'b0) begin
                repeat (C1 + C1 / 2) @(negedge clock);
                for (int i = 0; i < 8; i++) begin
                    b1[i] = txd1;
                    if (i < 7) repeat (C1) @(negedge clock);
                end
                repeat (C1) @(negedge clock);
                checks++;
                if (txd1 !== 1'b1) begin
                    errors++;
                    $display("FAIL stop1: txd=%b required 1", txd1);
                end
                checks++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL byte1: got %h, none expected", b1);
                end else begin
                    e1 = q1.pop_front();
                    if (b1 !== e1) begin
                        errors++;
                        $display("FAIL byte1: got %h required %h", b1, e1);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (txd2 === 1'b0) begin
                repeat (C2 + C2 / 2) @(negedge clock);
                for (int i = 0; i < 8; i++) begin
                    b2[i] = txd2;
                    if (i < 7) repeat (C2) @(negedge clock);
                end
                repeat (C2) @(negedge clock);
                checks++;
                if (txd2 !== 1'b1) begin
                    errors++;
                    $display("FAIL stop2: txd=%b required 1", txd2);
                end
                checks++;
                if (q2.size() == 0) begin
                    errors++;
                    $display("FAIL byte2: got %h, none expected", b2);
                end else begin
                    e2 = q2.pop_front();
                    if (b2 !== e2) begin
                        errors++;
                        $display("FAIL byte2: got %h required %h", b2, e2);
                    end
                end
            end
        end
    end

    task automatic push_frame1(input logic [47:0] p);
        logic [7:0] cs;
        q1.push_back(8'h55);
        q1.push_back(8'hAA);
        cs = 8'h55 ^ 8'hAA;
        for (int i = 5; i >= 0; i--) begin
            q1.push_back(p[i*8 +: 8]);
            cs = cs ^ p[i*8 +: 8];
        end
        q1.push_back(cs);
    endtask

    task automatic send1(input logic [47:0] p);
        @(negedge clock);
        payload1 = p;
        valid1 = 1'b1;
        checks++;
        if (ready1 !== 1'b1) begin
            errors++;
            $display("FAIL pre_accept: ready=%b required 1", ready1);
        end
        @(negedge clock);
        valid1 = 1'b0;
        checks++;
        if (txd1 !== 1'b0 || busy1 !== 1'b1 || ready1 !== 1'b0) begin
            errors++;
            $display("FAIL accept: txd/busy/ready=%b%b%b required 010",
                     txd1, busy1, ready1);
        end
    endtask

    task automatic wait_done1(input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clock);
            if (done1 === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL done1_timeout: no frame_done in %0d cycles", limit);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        valid1 = 1'b0;
        valid2 = 1'b0;
        payload1 = '0;
        payload2 = '0;
        repeat (3) @(negedge clock);
        checks++;
        if ({txd1, busy1, ready1, done1} !== 4'b1000) begin
            errors++;
            $display("FAIL reset1: txd/busy/ready/done=%b%b%b%b required 1000",
                     txd1, busy1, ready1, done1);
        end
        checks++;
        if ({txd2, busy2, ready2, done2} !== 4'b1000) begin
            errors++;
            $display("FAIL reset2: txd/busy/ready/done=%b%b%b%b required 1000",
                     txd2, busy2, ready2, done2);
        end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (ready1 !== 1'b1 || ready2 !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: ready1=%b ready2=%b required 1 1",
                     ready1, ready2);
        end
    endtask

    task automatic test_basic;
        bit seen;
        int dc0;
        dc0 = done_cnt1;
        busy_cnt1 = 0;
        push_frame1(48'h010203040506);
        send1(48'h010203040506);
        wait_done1(1000, seen);
        checks++;
        if (ready1 !== 1'b1 || txd1 !== 1'b1) begin
            errors++;
            $display("FAIL done_cycle: ready=%b txd=%b required 1 1", ready1, txd1);
        end
        @(negedge clock);
        checks++;
        if (busy_cnt1 != 360) begin
            errors++;
            $display("FAIL busy_len: got %0d required 360", busy_cnt1);
        end
        checks++;
        if (done_cnt1 - dc0 != 1) begin
            errors++;
            $display("FAIL done_pulses: got %0d required 1", done_cnt1 - dc0);
        end
        checks++;
        if (q1.size() != 0) begin
            errors++;
            $display("FAIL basic_bytes: %0d left required 0", q1.size());
        end
    endtask

    task automatic test_back_to_back;
        bit seen;
        int dc0;
        dc0 = done_cnt1;
        push_frame1(48'h010203040506);
        push_frame1(48'hA5C300FF1234);
        @(negedge clock);
        payload1 = 48'h010203040506;
        valid1 = 1'b1;
        @(negedge clock);
        payload1 = 48'hA5C300FF1234;
        checks++;
        if (busy1 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: busy=%b required 1", busy1);
        end
        wait_done1(1000, seen);
        checks++;
        if (txd1 !== 1'b1 || ready1 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_gap: txd=%b ready=%b required 1 1", txd1, ready1);
        end
        @(negedge clock);
        valid1 = 1'b0;
        checks++;
        if (txd1 !== 1'b0 || busy1 !== 1'b1 || ready1 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_start: txd/busy/ready=%b%b%b required 010",
                     txd1, busy1, ready1);
        end
        wait_done1(1000, seen);
        @(negedge clock);
        checks++;
        if (done_cnt1 - dc0 != 2) begin
            errors++;
            $display("FAIL b2b_pulses: got %0d required 2", done_cnt1 - dc0);
        end
        checks++;
        if (q1.size() != 0) begin
            errors++;
            $display("FAIL b2b_bytes: %0d left required 0", q1.size());
        end
    endtask

    task automatic test_payload_change;
        bit seen;
        push_frame1(48'h010203040506);
        send1(48'h010203040506);
        repeat (2 * 10 * C1 + 20) @(negedge clock);
        payload1 = '1;
        valid1 = 1'b0;
        wait_done1(1000, seen);
        @(negedge clock);
        payload1 = '0;
        checks++;
        if (q1.size() != 0) begin
            errors++;
            $display("FAIL change_bytes: %0d left required 0", q1.size());
        end
    endtask

    task automatic test_reset_mid_frame;
        int dc0;
        int bad_txd;
        mon_en1 = 1'b0;
        dc0 = done_cnt1;
        send1(48'h0F0E0D0C0B0A);
        repeat (10) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        checks++;
        if ({txd1, busy1, ready1, done1} !== 4'b1000) begin
            errors++;
            $display("FAIL abort: txd/busy/ready/done=%b%b%b%b required 1000",
                     txd1, busy1, ready1, done1);
        end
        @(negedge clock);
        checks++;
        if (ready1 !== 1'b1) begin
            errors++;
            $display("FAIL abort_ready: ready=%b required 1", ready1);
        end
        bad_txd = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (txd1 !== 1'b1) bad_txd++;
        end
        checks++;
        if (done_cnt1 != dc0 || bad_txd != 0) begin
            errors++;
            $display("FAIL abort_quiet: done pulses=%0d low txd=%0d required 0 0",
                     done_cnt1 - dc0, bad_txd);
        end
        mon_en1 = 1'b1;
    endtask

    task automatic test_valid_during_reset;
        bit seen;
        push_frame1(48'h8040201008FE);
        @(negedge clock);
        reset = 1'b0;
        valid1 = 1'b1;
        payload1 = 48'h8040201008FE;
        repeat (3) @(negedge clock);
        checks++;
        if ({txd1, busy1, ready1} !== 3'b100) begin
            errors++;
            $display("FAIL vrst_hold: txd/busy/ready=%b%b%b required 100",
                     txd1, busy1, ready1);
        end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({txd1, busy1, ready1} !== 3'b101) begin
            errors++;
            $display("FAIL vrst_first: txd/busy/ready=%b%b%b required 101",
                     txd1, busy1, ready1);
        end
        @(negedge clock);
        valid1 = 1'b0;
        checks++;
        if (txd1 !== 1'b0 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL vrst_accept: txd=%b busy=%b required 0 1", txd1, busy1);
        end
        wait_done1(1000, seen);
        @(negedge clock);
        checks++;
        if (q1.size() != 0) begin
            errors++;
            $display("FAIL vrst_bytes: %0d left required 0", q1.size());
        end
    endtask

    task automatic test_no_checksum;
        bit seen;
        int dc0;
        dc0 = done_cnt2;
        q2.push_back(8'h55);
        q2.push_back(8'hAA);
        q2.push_back(8'h00);
        busy_cnt2 = 0;
        @(negedge clock);
        payload2 = 8'h00;
        valid2 = 1'b1;
        @(negedge clock);
        valid2 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clock);
            if (done2 === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL done2_timeout: no frame_done in 300 cycles");
        end
        @(negedge clock);
        checks++;
        if (busy_cnt2 != 60) begin
            errors++;
            $display("FAIL busy_len2: got %0d required 60", busy_cnt2);
        end
        checks++;
        if (done_cnt2 - dc0 != 1 || q2.size() != 0) begin
            errors++;
            $display("FAIL nochk: pulses=%0d left=%0d required 1 0",
                     done_cnt2 - dc0, q2.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_payload_change();
        test_reset_mid_frame();
        test_valid_during_reset();
        test_no_checksum();
        repeat (5) @(negedge clock);
        checks++;
        if (q1.size() != 0 || q2.size() != 0) begin
            errors++;
            $display("FAIL leftover: q1=%0d q2=%0d required 0 0", q1.size(), q2.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lidar_frame_tx.md
LIDAR_FRAME_TX -- requirements
Module: lidar_frame_tx

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- CLKS_PER_BIT, 868, clock cycles per UART bit; legal range >= 2.
- PAYLOAD_BYTES, 6, payload bytes per frame; legal range 1..32.
- HEADER, 16'h55AA, frame header, sent high byte first.
- CHECKSUM_EN, 1, when 1 append an XOR checksum byte after the payload.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clock, in, 1: single clock; everything is on the rising edge.
- reset, in, 1: synchronous, active-low reset.
- frame_valid, in, 1: payload is offered.
- frame_ready, out, 1: block can accept a frame.
- payload, in, 8*PAYLOAD_BYTES: frame data; most significant byte is sent first.
- txd, out, 1: UART serial line; idle level is high.
- tx_busy, out, 1: a frame is in progress.
- frame_done, out, 1: one-cycle pulse at end of frame.

Function
REQ-003 The block SHALL accept a frame on a rising edge where frame_valid=1 and frame_ready=1; on that edge, payload is captured into an internal shift buffer.
REQ-004 Changes on payload or frame_valid after acceptance SHALL have no effect on the frame in flight.
REQ-005 Byte order SHALL be:
- HEADER[15:8];
- HEADER[7:0];
- payload bytes, MSB byte first;
- checksum byte, only if CHECKSUM_EN=1.
REQ-006 Checksum SHALL be the XOR of both header bytes and all payload bytes.
REQ-007 Each byte SHALL be sent as 8N1:
- one start bit (0);
- 8 data bits, LSB first;
- one stop bit (1);
- each bit held for exactly CLKS_PER_BIT cycles.
REQ-008 The FSM states SHALL be IDLE, START, DATA, STOP.
- IDLE -> START on acceptance.
- START -> DATA after CLKS_PER_BIT cycles.
- DATA -> STOP after 8 bits.
- STOP -> START if bytes remain.
- STOP -> IDLE after the final stop bit.
REQ-009 The start bit of the first byte SHALL appear on txd in the cycle after acceptance; there SHALL be no idle gap between bytes within a frame.
REQ-010 Total frame duration SHALL be (2+PAYLOAD_BYTES+CHECKSUM_EN)*10*CLKS_PER_BIT cycles.
REQ-011 Output timing SHALL be:
- tx_busy = 1 from the cycle after acceptance through the last stop-bit cycle inclusive.
- frame_ready = 1 exactly when the FSM is in IDLE and reset is not asserted.
REQ-012 frame_done SHALL pulse for one cycle, in the first IDLE cycle after a frame; frame_ready is also 1 in that cycle.
REQ-013 If frame_valid is held high across frames, the next frame SHALL be accepted in the frame_done cycle, giving exactly one idle-high txd cycle between frames.
REQ-014 All outputs SHALL be registered; txd SHALL be glitch-free.
REQ-015 The bit-period counter and byte counter SHALL be sized with $clog2 of their maxima; no counter SHALL wrap within a legal configuration.

Reset
REQ-016 While reset=0 at a clock edge, the block SHALL set:
- txd=1, tx_busy=0, frame_ready=0, frame_done=0;
- FSM to IDLE;
- all counters to 0.
REQ-017 frame_ready SHALL go to 1 on the first edge after reset returns to 1.
REQ-018 frame_valid SHALL be ignored while reset=0.
REQ-019 Reset mid-frame SHALL abort the frame: txd=1 at the next edge, with no frame_done pulse.

Structure
REQ-020 Package lidar_uart_pkg SHALL hold:
- the FSM state typedef;
- the default LiDAR header constant 16'h55AA;
- the UART framing constants: data bits 8, stop bits 1.
REQ-021 Byte serialisation (START/DATA/STOP and the bit timer) SHALL live in sub-module uart_byte_tx, with a byte-level valid/ready handshake; lidar_frame_tx SHALL sequence the bytes and compute the checksum.
REQ-022 Illegal parameter values SHALL cause an elaboration-time error.

Verification
REQ-023 The bench SHALL cover these scenarios:
- Basic frame (CLKS_PER_BIT=4, defaults, payload 48'h010203040506, one frame): txd decodes to 55 AA 01 02 03 04 05 06 F8; tx_busy high for 360 cycles; single frame_done pulse.
- Back-to-back (frame_valid held high for two frames): second start bit follows exactly one idle-high cycle after the first frame_done; 2 pulses total.
- Payload change mid-frame (payload changed to 48'hFFFFFFFFFFFF during byte 3): transmitted bytes unchanged from the captured value; checksum still F8.
- Reset mid-frame (reset=0 for 1 cycle during a DATA bit): next cycle txd=1, tx_busy=0, frame_ready=0; frame_ready=1 one cycle later; no frame_done.
- No checksum (CHECKSUM_EN=0, PAYLOAD_BYTES=1, CLKS_PER_BIT=2, payload 8'h00): bytes 55 AA 00; tx_busy high for 60 cycles.
- Valid during reset (frame_valid=1 while reset=0): no transmission; frame accepted on the first edge with frame_ready=1.
